// File: rtl/alu_sequencer.sv
// Sequencer that drives a combinational ALU from registered operands and returns results over valid/ready.
// Adds multi-step SRLN (repeated shift-right-by-one) and signed MAX (SLT followed by MOV).
module alu_sequencer #(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_data,
    output logic         resp_zero,
    output logic         resp_neg,
    output logic         resp_err,
    output logic [W-1:0] alu_dado1,
    output logic [W-1:0] alu_dado2,
    output logic [2:0]   alu_controle,
    input  logic [W-1:0] alu_saida,
    input  logic         alu_zero,
    input  logic         alu_neg
);

    typedef enum logic [2:0] {IDLE, EXEC, SHIFT, MAX2, RESP} state_t;

    localparam logic [2:0] CTL_MOV = 3'b100;
    localparam logic [2:0] CTL_SHR = 3'b101;
    localparam logic [2:0] CTL_SLT = 3'b110;

    state_t         state_reg, state_next;
    logic [3:0]     op_reg;
    logic [W-1:0]   a_reg, b_reg, data_reg;
    logic [SHW-1:0] cnt_reg;
    logic           lt_reg, zero_reg, neg_reg, err_reg;

    logic accept, reserved, latch, shift_step;

    assign accept     = (state_reg == IDLE) && req_valid;
    assign reserved   = (req_op > 4'd9);
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_data  = data_reg;
    assign resp_zero  = zero_reg;
    assign resp_neg   = neg_reg;
    assign resp_err   = err_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        alu_dado1    = '0;
        alu_dado2    = '0;
        alu_controle = 3'b000;
        latch        = 1'b0;
        shift_step   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = reserved ? RESP : EXEC;
                end
            end
            EXEC: begin
                alu_dado1 = a_reg;
                alu_dado2 = b_reg;
                if (!op_reg[3]) begin
                    alu_controle = op_reg[2:0];
                    latch        = 1'b1;
                    state_next   = RESP;
                end else if (op_reg == 4'd8) begin
                    if (cnt_reg == '0) begin
                        alu_controle = CTL_MOV;
                        latch        = 1'b1;
                        state_next   = RESP;
                    end else begin
                        alu_controle = CTL_SHR;
                        shift_step   = 1'b1;
                        if (cnt_reg == SHW'(1)) begin
                            latch      = 1'b1;
                            state_next = RESP;
                        end else begin
                            state_next = SHIFT;
                        end
                    end
                end else begin
                    alu_controle = CTL_SLT;
                    state_next   = MAX2;
                end
            end
            SHIFT: begin
                alu_dado1    = a_reg;
                alu_dado2    = b_reg;
                alu_controle = CTL_SHR;
                shift_step   = 1'b1;
                if (cnt_reg == SHW'(1)) begin
                    latch      = 1'b1;
                    state_next = RESP;
                end
            end
            MAX2: begin
                // Ties leave LT clear, so A is returned
                alu_dado1    = lt_reg ? b_reg : a_reg;
                alu_dado2    = b_reg;
                alu_controle = CTL_MOV;
                latch        = 1'b1;
                state_next   = RESP;
            end
            RESP: begin
                alu_dado2 = b_reg;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_reg   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            cnt_reg  <= '0;
            lt_reg   <= 1'b0;
            data_reg <= '0;
            zero_reg <= 1'b0;
            neg_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                op_reg  <= req_op;
                a_reg   <= req_a;
                b_reg   <= req_b;
                cnt_reg <= req_b[SHW-1:0];
                err_reg <= reserved;
                if (reserved) begin
                    data_reg <= '0;
                    zero_reg <= 1'b1;
                    neg_reg  <= 1'b0;
                end
            end
            if (shift_step) begin
                a_reg   <= alu_saida;
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (state_reg == EXEC && op_reg == 4'd9) begin
                lt_reg <= alu_saida[0];
            end
            if (latch) begin
                data_reg <= alu_saida;
                zero_reg <= alu_zero;
                neg_reg  <= alu_neg;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with a behavioural ALU model on the ALU side.
module tb_alu_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = '0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_data;
    logic         resp_zero, resp_neg, resp_err;
    logic [W-1:0] alu_dado1, alu_dado2;
    logic [2:0]   alu_controle;
    logic [W-1:0] alu_saida;
    logic         alu_zero, alu_neg;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_sequencer #(.W(W), .SHW(5)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_zero(resp_zero), .resp_neg(resp_neg), .resp_err(resp_err),
        .alu_dado1(alu_dado1), .alu_dado2(alu_dado2), .alu_controle(alu_controle),
        .alu_saida(alu_saida), .alu_zero(alu_zero), .alu_neg(alu_neg)
    );

    // Behavioural model of the external combinational ALU
    always_comb begin
        alu_saida = '0;
        case (alu_controle)
            3'd0: alu_saida = alu_dado1 + alu_dado2;
            3'd1: alu_saida = alu_dado1 - alu_dado2;
            3'd2: alu_saida = alu_dado1 & alu_dado2;
            3'd3: alu_saida = alu_dado1 | alu_dado2;
            3'd4: alu_saida = alu_dado1;
            3'd5: alu_saida = alu_dado1 >> 1;
            3'd6: alu_saida = {31'b0, $signed(alu_dado1) < $signed(alu_dado2)};
            default: alu_saida = alu_dado1 ^ alu_dado2;
        endcase
        alu_zero = (alu_saida == '0);
        alu_neg  = alu_saida[W-1];
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic         zero;
        logic         neg;
        logic         err;
        int           lat;
        int           shifts;
    } vec_t;

    // Issue one request with resp_ready=1 and check the response, latency and shift count
    task automatic run_vec(input vec_t v);
        int edges;
        int sh;
        edges = 0;
        sh = 0;
        @(negedge clock);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op = v.op;
        req_a = v.a;
        req_b = v.b;
        @(posedge clock);
        edges = 1;
        #1;
        req_valid = 1'b0;
        while (!resp_valid && edges < 100) begin
            if (alu_controle == 3'd5) sh++;
            @(posedge clock);
            edges++;
            #1;
        end
        if (!resp_valid) begin
            errors++;
            checks++;
            $display("FAIL timeout op=%0d edges=%0d required response", v.op, edges);
        end
        $display("op=%0d a=0x%0h b=0x%0h -> data=0x%0h z=%0b n=%0b e=%0b lat=%0d shifts=%0d",
                 v.op, v.a, v.b, resp_data, resp_zero, resp_neg, resp_err, edges, sh);
        check("data", resp_data, v.data);
        check("zero", {31'b0, resp_zero}, {31'b0, v.zero});
        check("neg", {31'b0, resp_neg}, {31'b0, v.neg});
        check("err", {31'b0, resp_err}, {31'b0, v.err});
        check("latency", W'(edges), W'(v.lat));
        check("shift_steps", W'(sh), W'(v.shifts));
        check("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
        @(posedge clock);
        #1;
        check("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[1]  = '{4'd1, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 2, 0};
        vecs[2]  = '{4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 2, 0};
        vecs[3]  = '{4'd8, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 1'b0, 32, 31};
        vecs[4]  = '{4'd8, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[5]  = '{4'd8, 32'h0000_00F0, 32'd4, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 5, 4};
        vecs[6]  = '{4'd8, 32'hFFFF_FFFF, 32'h21, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 2, 1};
        vecs[7]  = '{4'd9, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 3, 0};
        vecs[8]  = '{4'd9, 32'd7, 32'hFFFF_FFF7, 32'd7, 1'b0, 1'b0, 1'b0, 3, 0};
        vecs[9]  = '{4'd9, 32'd4, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 3, 0};
        vecs[10] = '{4'd9, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 3, 0};
        vecs[11] = '{4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 2, 0};
        vecs[12] = '{4'd12, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1, 1, 0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_flags", {29'b0, resp_zero, resp_neg, resp_err}, 32'd0);
        check("rst_dado1", alu_dado1, 32'd0);
        check("rst_dado2", alu_dado2, 32'd0);
        check("rst_controle", {29'b0, alu_controle}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: response must hold and no second request may be taken
        resp_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b1;
        req_op = 4'd0;
        req_a = 32'd1;
        req_b = 32'd2;
        @(posedge clock);
        @(negedge clock);
        req_op = 4'd0;
        req_a = 32'd100;
        req_b = 32'd100;
        @(posedge clock);
        #1;
        check("stall_valid_start", {31'b0, resp_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            $display("stall cycle=%0d valid=%0b ready=%0b data=0x%0h", c, resp_valid, req_ready, resp_data);
            check("stall_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_data", resp_data, 32'd3);
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clock);
        resp_ready = 1'b1;
        req_op = 4'd12;
        @(posedge clock);
        #1;
        check("stall_release_idle", {31'b0, resp_valid}, 32'd0);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        $display("reserved op=12 valid=%0b data=0x%0h err=%0b", resp_valid, resp_data, resp_err);
        check("rsv_valid", {31'b0, resp_valid}, 32'd1);
        check("rsv_err", {31'b0, resp_err}, 32'd1);
        check("rsv_data", resp_data, 32'd0);
        @(posedge clock);
        #1;

        // Asynchronous reset in the middle of a long shift
        @(negedge clock);
        req_valid = 1'b1;
        req_op = 4'd8;
        req_a = 32'hFFFF_FFFF;
        req_b = 32'd20;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("pre_rst_shifting", {29'b0, alu_controle}, 32'd5);
        #1;
        reset_n = 1'b0;
        #1;
        $display("async reset mid-shift controle=%0d valid=%0b", alu_controle, resp_valid);
        check("arst_controle", {29'b0, alu_controle}, 32'd0);
        check("arst_dado1", alu_dado1, 32'd0);
        check("arst_dado2", alu_dado2, 32'd0);
        check("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            check("arst_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        run_vec('{4'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 2, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
